// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : AHB-Lite encodings and the transfer alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Sizes wider than a word are never legal on this 32-bit bus.
    function automatic logic ahb_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_cmd_master_if
// Purpose  : Command/response port plus AHB-Lite master-side bus signals.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_cmd_master_if #(
    parameter int P_ADDR_W = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [P_ADDR_W-1:0] cmd_addr;
    logic [2:0]          cmd_size;
    logic [31:0]         cmd_wdata;

    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_error;

    logic [P_ADDR_W-1:0] HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic [31:0]         HWDATA;
    logic [31:0]         HRDATA;
    logic [1:0]          HRESP;
    logic                HREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HRESP, HREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HRESP, HREADY
    );
endinterface
`default_nettype wire

// File: rtl/ahb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_cmd_master
// Purpose  : valid/ready command stream to pipelined AHB-Lite single transfers,
//            one in-order response per command.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int P_ADDR_W      = 32,
    parameter bit P_CHECK_ALIGN = 1'b1
) (
    input  wire logic        HCLK,
    input  wire logic        HRESET,
    ahb_cmd_master_if.master bus
);

    logic [1:0]          ap_trans_q, ap_trans_d;
    logic [P_ADDR_W-1:0] ap_addr_q,  ap_addr_d;
    logic                ap_write_q, ap_write_d;
    logic [2:0]          ap_size_q,  ap_size_d;
    logic [31:0]         ap_wdata_q, ap_wdata_d;

    logic                dp_valid_q, dp_valid_d;
    logic                dp_write_q, dp_write_d;
    logic [31:0]         hwdata_q,   hwdata_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_error_q, rsp_error_d;

    logic w_aligned;
    logic w_pipe_busy;
    logic w_cmd_ready;
    logic w_accept;
    logic w_dp_done;

    assign w_aligned   = (P_CHECK_ALIGN == 1'b0) || ahb_aligned(bus.cmd_size, bus.cmd_addr[1:0]);
    assign w_pipe_busy = (ap_trans_q == HTRANS_NONSEQ) || dp_valid_q;
    // A misaligned command must wait for an empty pipe so its response stays in order.
    assign w_cmd_ready = bus.HREADY && !HRESET && !(!w_aligned && w_pipe_busy);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_dp_done   = dp_valid_q && bus.HREADY;

    always_comb begin
        ap_trans_d  = ap_trans_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_error_d = 1'b0;

        if (bus.HREADY) begin
            dp_valid_d = (ap_trans_q == HTRANS_NONSEQ);
            dp_write_d = ap_write_q;
            hwdata_d   = ap_wdata_q;
            ap_trans_d = HTRANS_IDLE;
            if (w_accept && w_aligned) begin
                ap_trans_d = HTRANS_NONSEQ;
                ap_addr_d  = bus.cmd_addr;
                ap_write_d = bus.cmd_write;
                ap_size_d  = bus.cmd_size;
                ap_wdata_d = bus.cmd_wdata;
            end
        end

        if (w_dp_done) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = (bus.HRESP == HRESP_ERROR);
            rsp_rdata_d = dp_write_q ? 32'h0 : bus.HRDATA;
        end else if (w_accept && !w_aligned) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_trans_q  <= HTRANS_IDLE;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= HSIZE_WORD;
            ap_wdata_q  <= 32'h0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            ap_trans_q  <= ap_trans_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.HTRANS    = ap_trans_q;
    assign bus.HADDR     = ap_addr_q;
    assign bus.HWRITE    = ap_write_q;
    assign bus.HSIZE     = ap_size_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HWDATA    = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_cmd_master
// Purpose  : Scoreboard bench for ahb_cmd_master with a wait/error memory slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_cmd_master;
    import ahb_pkg::*;

    localparam logic [31:0] c_err_pat  = 32'hBAD0_0000;
    localparam logic [31:0] c_err_base = 32'h0000_0100;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          on_bus;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  sz;
    } ap_t;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb_cmd_master_if #(.P_ADDR_W(32)) bus ();

    ahb_cmd_master #(.P_ADDR_W(32), .P_CHECK_ALIGN(1'b1)) u_dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    rsp_t rsp_q[$];
    ap_t  ap_q[$];
    rsp_t mon_e;
    ap_t  mon_a;
    bit   checking     = 1'b0;
    int   outstanding  = 0;
    int   rsp_cnt      = 0;
    int   last_rsp_cyc = 0;
    logic [31:0] last_rdata = 32'h0;
    int   acc_cyc      = 0;
    int   wait_lo      = 0;
    int   wait_hi      = 0;
    logic [7:0] mmod [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_aligned(input logic [2:0] sz, input logic [31:0] a);
        int nbytes;
        if (sz > 3'd2) return 1'b0;
        nbytes = 1 << sz;
        return (int'(a) % nbytes) == 0;
    endfunction

    // ---------------- memory slave with wait states; 0x100..0x1FF answers ERROR
    logic        s_act, s_write, s_err, s_ph2;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    int          s_wait;
    logic [31:0] smem [0:63];
    logic        s_hready;
    logic [1:0]  s_hresp;
    logic [31:0] s_hrdata;
    logic [3:0]  s_lanes;

    always_comb begin
        s_hready = 1'b1;
        s_hresp  = HRESP_OKAY;
        s_hrdata = 32'h0;
        if (s_act) begin
            if (s_wait > 0) begin
                s_hready = 1'b0;
            end else if (s_err) begin
                s_hresp  = HRESP_ERROR;
                s_hready = s_ph2;
                s_hrdata = c_err_pat | s_addr;
            end else if (!s_write) begin
                s_hrdata = smem[s_addr[7:2]];
            end
        end
    end

    always_comb begin
        case (s_size)
            3'd0:    s_lanes = 4'b0001 << s_addr[1:0];
            3'd1:    s_lanes = 4'b0011 << s_addr[1:0];
            default: s_lanes = 4'b1111;
        endcase
    end

    assign bus.HREADY = s_hready;
    assign bus.HRESP  = s_hresp;
    assign bus.HRDATA = s_hrdata;

    always @(posedge HCLK) begin
        if (HRESET) begin
            s_act <= 1'b0;
            s_ph2 <= 1'b0;
            s_wait <= 0;
        end else if (s_hready) begin
            if (s_act && s_write && !s_err)
                for (int b = 0; b < 4; b++)
                    if (s_lanes[b]) smem[s_addr[7:2]][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            s_act   <= (bus.HTRANS == HTRANS_NONSEQ);
            s_addr  <= bus.HADDR;
            s_write <= bus.HWRITE;
            s_size  <= bus.HSIZE;
            s_err   <= (bus.HADDR >= c_err_base);
            s_ph2   <= 1'b0;
            s_wait  <= int'($urandom_range(wait_hi, wait_lo));
        end else if (s_wait > 0) begin
            s_wait <= s_wait - 1;
        end else begin
            s_ph2 <= 1'b1;
        end
    end

    // ---------------- monitor
    always @(negedge HCLK) begin
        if (checking) begin
            if (bus.rsp_valid) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                last_rdata   = bus.rsp_rdata;
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
                end else begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                    check("rsp_error", 32'(bus.rsp_error), 32'(mon_e.err));
                    if (mon_e.on_bus) outstanding--;
                end
            end
            check("cmd_ready", 32'(bus.cmd_ready),
                  32'(bus.HREADY && !(!ref_aligned(bus.cmd_size, bus.cmd_addr) && outstanding > 0)));
            check("hburst", 32'(bus.HBURST), 32'h0);
            if (bus.HTRANS == HTRANS_BUSY || bus.HTRANS == HTRANS_SEQ) begin
                total++; bad++;
                $display("FAIL htrans_kind: got %b expected 00 or 10", bus.HTRANS);
            end
            if (bus.HTRANS == HTRANS_NONSEQ && bus.HREADY) begin
                if (ap_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_unexpected: got NONSEQ at %h expected IDLE", bus.HADDR);
                end else begin
                    mon_a = ap_q.pop_front();
                    check("haddr",  bus.HADDR, mon_a.addr);
                    check("hwrite", 32'(bus.HWRITE), 32'(mon_a.wr));
                    check("hsize",  32'(bus.HSIZE), 32'(mon_a.sz));
                end
            end
        end
    end

    // ---------------- driver + reference model
    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int   n = 0;
        int   idx;
        rsp_t e;
        bit   al;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_size  = sz;
        bus.cmd_wdata = wd;
        @(negedge HCLK);
        while (!bus.cmd_ready && n < 100) begin
            n++;
            @(negedge HCLK);
        end
        if (!bus.cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got cmd_ready=0 for %0d cycles expected accept", n);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge HCLK);
        #1;
        acc_cyc  = cyc;
        al       = ref_aligned(sz, a);
        e.on_bus = al;
        e.rdata  = 32'h0;
        e.err    = 1'b0;
        if (!al) begin
            e.err = 1'b1;
        end else if (a >= c_err_base) begin
            e.err = 1'b1;
            if (!wr) e.rdata = c_err_pat | a;
        end else if (wr) begin
            for (int k = 0; k < (1 << sz); k++) begin
                idx = int'(a) + k;
                mmod[8'(idx)] = wd[8*(idx % 4) +: 8];
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = int'(a & ~32'd3) + k;
                e.rdata[8*k +: 8] = mmod[8'(idx)];
            end
        end
        rsp_q.push_back(e);
        if (al) begin
            ap_q.push_back('{addr: a, wr: wr, sz: sz});
            outstanding++;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_size  = HSIZE_WORD;
        bus.cmd_wdata = 32'h0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (rsp_q.size() != 0 && n < 300) begin
            @(posedge HCLK);
            n++;
        end
        if (rsp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_drain: got %0d pending responses expected 0", name, rsp_q.size());
            rsp_q.delete();
            ap_q.delete();
            outstanding = 0;
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          t1;
        int          cnt0;
        int          gap;
        logic [2:0]  sz;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) mmod[i] = 8'h0;
        for (int i = 0; i < 64; i++)  smem[i] = 32'h0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_size  = HSIZE_WORD;
        bus.cmd_wdata = 32'h0;

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_htrans",    32'(bus.HTRANS), 32'h0);
        check("rst_haddr",     bus.HADDR, 32'h0);
        check("rst_hwrite",    32'(bus.HWRITE), 32'h0);
        check("rst_hsize",     32'(bus.HSIZE), 32'h2);
        check("rst_hburst",    32'(bus.HBURST), 32'h0);
        check("rst_hwdata",    bus.HWDATA, 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        @(posedge HCLK);
        #1;
        HRESET   = 1'b0;
        checking = 1'b1;

        // zero-wait write then read; response in the cycle after edge accept+2
        issue(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        issue(1'b0, 32'h10, HSIZE_WORD, 32'h0);
        t0 = acc_cyc;
        drain("rd0");
        check("rd0_latency", 32'(last_rsp_cyc - t0), 32'd2);
        check("rd0_data", last_rdata, 32'hDEADBEEF);

        // back-to-back: one accept per cycle
        issue(1'b1, 32'h0, HSIZE_WORD, $urandom);
        t0 = acc_cyc;
        issue(1'b1, 32'h4, HSIZE_WORD, $urandom);
        issue(1'b1, 32'h8, HSIZE_WORD, $urandom);
        issue(1'b1, 32'hC, HSIZE_WORD, $urandom);
        check("b2b_wr_span", 32'(acc_cyc - t0), 32'd3);
        issue(1'b0, 32'h0, HSIZE_WORD, 32'h0);
        t0 = acc_cyc;
        issue(1'b0, 32'h4, HSIZE_WORD, 32'h0);
        issue(1'b0, 32'h8, HSIZE_WORD, 32'h0);
        issue(1'b0, 32'hC, HSIZE_WORD, 32'h0);
        check("b2b_rd_span", 32'(acc_cyc - t0), 32'd3);
        drain("b2b");

        // two wait states in the data phase
        wait_lo = 2; wait_hi = 2;
        issue(1'b0, 32'h10, HSIZE_WORD, 32'h0);
        t0 = acc_cyc;
        drain("wait2");
        check("wait2_latency", 32'(last_rsp_cyc - t0), 32'd4);
        wait_lo = 0; wait_hi = 0;

        // byte lane merge
        issue(1'b1, 32'h10, HSIZE_WORD, 32'h11223344);
        issue(1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000);
        issue(1'b0, 32'h10, HSIZE_WORD, 32'h0);
        drain("byte");
        check("byte_merge", last_rdata, 32'hAA223344);

        // misaligned, idle and behind an in-flight transfer
        issue(1'b1, 32'h1, HSIZE_HALF, 32'h0000BEEF);
        t0 = acc_cyc;
        drain("mis_idle");
        check("mis_latency", 32'(last_rsp_cyc - t0), 32'd0);
        issue(1'b1, 32'h20, HSIZE_WORD, 32'h55667788);
        t0 = acc_cyc;
        issue(1'b1, 32'h1, HSIZE_HALF, 32'h0000BEEF);
        check("mis_wait_drain", 32'(acc_cyc - t0), 32'd3);
        drain("mis_busy");

        // ERROR read followed by a queued OKAY read
        issue(1'b0, 32'h140, HSIZE_WORD, 32'h0);
        issue(1'b0, 32'h20, HSIZE_WORD, 32'h0);
        drain("err");
        check("err_next_data", last_rdata, 32'h55667788);

        // reset during a stalled data phase
        wait_lo = 3; wait_hi = 3;
        issue(1'b0, 32'h150, HSIZE_WORD, 32'h0);
        cnt0 = rsp_cnt;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        checking = 1'b0;
        HRESET   = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        rsp_q.delete();
        ap_q.delete();
        outstanding = 0;
        wait_lo = 0; wait_hi = 0;
        @(negedge HCLK);
        check("rst_mid_htrans", 32'(bus.HTRANS), 32'h0);
        checking = 1'b1;
        repeat (8) @(posedge HCLK);
        #1;
        check("rst_mid_no_rsp", 32'(rsp_cnt), 32'(cnt0));

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            wait_hi = $urandom_range(0, 2);
            sz = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) sz = 3'd3;
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) a = a | c_err_base;
            issue(1'($urandom_range(0, 1)), a, sz, $urandom);
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge HCLK);
                #1;
            end
        end
        drain("rand");
        t1 = rsp_cnt;
        check("rand_rsp_seen", 32'(t1 > cnt0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
